// File: rtl/conway_sequencer.sv
// Sequencer for the Conway grid memory: serial grid load, then free-run or single-step generations.
// Optional generation counter: define CONWAY_SEQ_GEN_COUNT_EN to build it (otherwise gen_count is 0).
module conway_sequencer #(
    parameter int DATA_SIZE = 8,
    parameter int GEN_DIV   = 4,
    parameter int GEN_W     = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_start,
    input  logic             serial_valid,
    input  logic             serial_data,
    input  logic             run_enable,
    input  logic             step,
    output logic             mem_serial,
    output logic             mem_load,
    output logic             mem_run,
    output logic             load_done,
    output logic             busy,
    output logic [GEN_W-1:0] gen_count
);

    // state | meaning
    // IDLE  | no complete grid loaded yet; only load_start is honoured
    // LOAD  | shifting DATA_SIZE serial bits into memory
    // HALT  | grid loaded, waiting for run_enable, step or a new load
    // RUN   | free-running, one generation every GEN_DIV cycles
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HALT = 2'd2,
        ST_RUN  = 2'd3
    } state_e;

    localparam int CW = $clog2(DATA_SIZE + 1);
    localparam int PW = (GEN_DIV > 1) ? $clog2(GEN_DIV) : 1;
    localparam logic [PW-1:0] PRE_TC = PW'(GEN_DIV - 1);

    state_e         state_q, state_d;
    logic [CW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [PW-1:0]  pre_q, pre_d;
    logic           mem_serial_q, mem_serial_d;
    logic           mem_load_q, mem_load_d;
    logic           mem_run_q, mem_run_d;
    logic           load_done_q, load_done_d;
    logic           busy_q, busy_d;
    logic           gen_inc, gen_clr;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        pre_d        = pre_q;
        mem_serial_d = 1'b0;
        mem_load_d   = 1'b0;
        mem_run_d    = 1'b0;
        load_done_d  = 1'b0;
        gen_inc      = 1'b0;
        gen_clr      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    state_d   = ST_LOAD;
                    bit_cnt_d = '0;
                    gen_clr   = 1'b1;
                end
            end
            ST_LOAD: begin
                if (serial_valid) begin
                    mem_load_d   = 1'b1;
                    mem_serial_d = serial_data;
                    bit_cnt_d    = bit_cnt_q + CW'(1);
                    if (bit_cnt_q == CW'(DATA_SIZE - 1)) begin
                        load_done_d = 1'b1;
                        state_d     = ST_HALT;
                    end
                end
            end
            ST_HALT: begin
                if (load_start) begin
                    state_d   = ST_LOAD;
                    bit_cnt_d = '0;
                    gen_clr   = 1'b1;
                end else if (run_enable) begin
                    state_d = ST_RUN;
                    pre_d   = PRE_TC;
                end else if (step) begin
                    mem_run_d = 1'b1;
                    gen_inc   = 1'b1;
                end
            end
            ST_RUN: begin
                // Leaving RUN never issues the pending generation.
                if (load_start) begin
                    state_d   = ST_LOAD;
                    bit_cnt_d = '0;
                    gen_clr   = 1'b1;
                end else if (!run_enable) begin
                    state_d = ST_HALT;
                    pre_d   = PRE_TC;
                end else if (pre_q == '0) begin
                    mem_run_d = 1'b1;
                    gen_inc   = 1'b1;
                    pre_d     = PRE_TC;
                end else begin
                    pre_d = pre_q - PW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_LOAD) || (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            pre_q        <= PRE_TC;
            mem_serial_q <= 1'b0;
            mem_load_q   <= 1'b0;
            mem_run_q    <= 1'b0;
            load_done_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            pre_q        <= pre_d;
            mem_serial_q <= mem_serial_d;
            mem_load_q   <= mem_load_d;
            mem_run_q    <= mem_run_d;
            load_done_q  <= load_done_d;
            busy_q       <= busy_d;
        end
    end

    assign mem_serial = mem_serial_q;
    assign mem_load   = mem_load_q;
    assign mem_run    = mem_run_q;
    assign load_done  = load_done_q;
    assign busy       = busy_q;

`ifdef CONWAY_SEQ_GEN_COUNT_EN
    logic [GEN_W-1:0] gen_count_q, gen_count_d;

    always_comb begin
        gen_count_d = gen_count_q;
        if (gen_clr) begin
            gen_count_d = '0;
        end else if (gen_inc) begin
            gen_count_d = gen_count_q + GEN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gen_count_q <= '0;
        end else begin
            gen_count_q <= gen_count_d;
        end
    end

    assign gen_count = gen_count_q;
`else
    logic unused_gen;
    assign unused_gen = gen_inc ^ gen_clr;
    assign gen_count  = '0;
`endif

endmodule

// File: tb/tb_conway_sequencer.sv
// Self-checking bench for conway_sequencer: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the sequencer.
module tb_conway_sequencer;

    localparam int DS = 8;
    localparam int GD = 4;
    localparam int GW = 2;
`ifdef CONWAY_SEQ_GEN_COUNT_EN
    localparam bit GC_EN = 1'b1;
`else
    localparam bit GC_EN = 1'b0;
`endif

    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_HALT = 2;
    localparam int M_RUN  = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          load_start = 1'b0;
    logic          serial_valid = 1'b0;
    logic          serial_data = 1'b0;
    logic          run_enable = 1'b0;
    logic          step = 1'b0;
    logic          mem_serial, mem_load, mem_run, load_done, busy;
    logic [GW-1:0] gen_count;

    always #5 clk = ~clk;

    conway_sequencer #(.DATA_SIZE(DS), .GEN_DIV(GD), .GEN_W(GW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .load_start   (load_start),
        .serial_valid (serial_valid),
        .serial_data  (serial_data),
        .run_enable   (run_enable),
        .step         (step),
        .mem_serial   (mem_serial),
        .mem_load     (mem_load),
        .mem_run      (mem_run),
        .load_done    (load_done),
        .busy         (busy),
        .gen_count    (gen_count)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // behavioural model: mode, bits loaded, cycles spent in RUN, generations issued
    int   m_mode = M_IDLE;
    int   m_bits = 0;
    int   m_runcyc = 0;
    int   m_gen = 0;
    logic e_load, e_serial, e_run, e_done, e_busy;

    // monitor record
    int          load_pulses = 0;
    int          done_pulses = 0;
    logic [7:0]  cap = '0;
    int          run_q[$];

    always @(posedge clk) begin
        cyc++;
        e_load = 1'b0; e_run = 1'b0; e_done = 1'b0; e_serial = 1'b0;
        if (!reset_n) begin
            m_mode = M_IDLE;
            m_gen  = 0;
        end else begin
            case (m_mode)
                M_IDLE: if (load_start) begin m_mode = M_LOAD; m_bits = 0; m_gen = 0; end
                M_LOAD: if (serial_valid) begin
                    e_load = 1'b1; e_serial = serial_data; m_bits++;
                    if (m_bits == DS) begin e_done = 1'b1; m_mode = M_HALT; end
                end
                M_HALT: begin
                    if (load_start) begin m_mode = M_LOAD; m_bits = 0; m_gen = 0; end
                    else if (run_enable) begin m_mode = M_RUN; m_runcyc = 0; end
                    else if (step) begin e_run = 1'b1; m_gen = (m_gen + 1) % (1 << GW); end
                end
                default: begin
                    if (load_start) begin m_mode = M_LOAD; m_bits = 0; m_gen = 0; end
                    else if (!run_enable) m_mode = M_HALT;
                    else begin
                        m_runcyc++;
                        if (m_runcyc % GD == 0) begin e_run = 1'b1; m_gen = (m_gen + 1) % (1 << GW); end
                    end
                end
            endcase
        end
        e_busy = (m_mode == M_LOAD) || (m_mode == M_RUN);
        #1;
        chk("mem_load", mem_load, e_load);
        chk("mem_run", mem_run, e_run);
        chk("load_done", load_done, e_done);
        chk("busy", busy, e_busy);
        chk("gen_count", gen_count, GC_EN ? m_gen : 0);
        if (e_load) chk("mem_serial", mem_serial, e_serial);
        chk("load_run_exclusive", mem_load & mem_run, 1'b0);
        if (mem_load) begin load_pulses++; cap = {cap[6:0], mem_serial}; end
        if (load_done) done_pulses++;
        if (mem_run) run_q.push_back(cyc);
    end

    task automatic start_load();
        load_start   = 1'b1;
        serial_valid = 1'b1;
        serial_data  = 1'b1;
        @(negedge clk);
        load_start   = 1'b0;
        serial_valid = 1'b0;
        serial_data  = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            serial_valid = 1'b1;
            serial_data  = b[7-i];
            @(negedge clk);
            serial_valid = 1'b0;
            serial_data  = 1'b0;
            @(negedge clk);
        end
    endtask

    int e_start;
    int d0;

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        chk("rst_mem_load", mem_load, 1'b0);
        chk("rst_mem_run", mem_run, 1'b0);
        chk("rst_load_done", load_done, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_gen_count", gen_count, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // step / run_enable ignored in IDLE
        run_q.delete();
        step = 1'b1; @(negedge clk); step = 1'b0;
        run_enable = 1'b1; repeat (3) @(negedge clk); run_enable = 1'b0;
        @(negedge clk);
        chk("idle_no_run", run_q.size(), 0);
        chk("idle_not_busy", busy, 1'b0);

        // load 1,0,1,1,0,0,1,0 with gaps
        load_pulses = 0; done_pulses = 0;
        start_load();
        chk("load_busy", busy, 1'b1);
        send_bits(8'hB2, DS);
        chk("load_pulses", load_pulses, 8);
        chk("load_bits", cap, 8'hB2);
        chk("load_done_cnt", done_pulses, 1);
        chk("load_busy_fall", busy, 1'b0);

        // two back-to-back steps in HALT
        run_q.delete();
        step = 1'b1; repeat (2) @(negedge clk); step = 1'b0;
        repeat (2) @(negedge clk);
        chk("step_pulses", run_q.size(), 2);
        chk("step_consecutive", run_q[1] - run_q[0], 1);
        chk("step_gen", gen_count, GC_EN ? 2 : 0);

        // three more spaced steps: 5 total wraps to 1 in 2 bits
        for (int i = 0; i < 3; i++) begin
            step = 1'b1; @(negedge clk); step = 1'b0; @(negedge clk);
        end
        chk("step_wrap_gen", gen_count, GC_EN ? 1 : 0);

        // reload, then free-run for 13 cycles
        start_load();
        send_bits(8'h5C, DS);
        chk("reload_gen_clear", gen_count, 0);
        run_q.delete();
        run_enable = 1'b1;
        e_start = cyc + 1;
        repeat (13) @(negedge clk);
        run_enable = 1'b0;
        repeat (6) @(negedge clk);
        chk("run_pulses", run_q.size(), 3);
        chk("run_first", run_q[0] - e_start, 4);
        chk("run_second", run_q[1] - e_start, 8);
        chk("run_third", run_q[2] - e_start, 12);
        chk("run_gen", gen_count, GC_EN ? 3 : 0);
        chk("run_halt_busy", busy, 1'b0);

        // load_start mid-prescale aborts the run
        run_q.delete();
        run_enable = 1'b1;
        repeat (2) @(negedge clk);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        run_enable = 1'b0;
        @(negedge clk);
        chk("abort_no_run", run_q.size(), 0);
        chk("abort_gen", gen_count, 0);
        chk("abort_in_load", busy, 1'b1);
        d0 = done_pulses;
        send_bits(8'h93, DS);
        chk("abort_reload_done", done_pulses - d0, 1);

        // reset after 5 of 8 bits, then a full fresh load
        start_load();
        send_bits(8'hFF, 5);
        reset_n = 1'b0;
        #1;
        chk("midrst_load", mem_load, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        d0 = done_pulses;
        start_load();
        send_bits(8'hA7, 7);
        chk("fresh_7_no_done", done_pulses - d0, 0);
        send_bits(8'h80, 1);
        chk("fresh_8_done", done_pulses - d0, 1);

        // randomized traffic, checked every cycle by the model
        for (int i = 0; i < 4000; i++) begin
            load_start   = ($urandom_range(0, 29) == 0);
            serial_valid = $urandom_range(0, 1);
            serial_data  = $urandom_range(0, 1);
            if ($urandom_range(0, 39) == 0) run_enable = ~run_enable;
            step    = !run_enable && ($urandom_range(0, 5) == 0);
            reset_n = ($urandom_range(0, 799) != 0);
            @(negedge clk);
        end
        reset_n = 1'b1; load_start = 1'b0; serial_valid = 1'b0;
        run_enable = 1'b0; step = 1'b0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
